// File: rtl/count_mod_n.sv
// Up/down counter with a programmable 0..limit range: wrap, saturate and one-shot end modes.
// Latency: 1 cycle from an accepted step to count/tic. There is no backpressure; en is sampled every edge.
module count_mod_n #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  input  logic [1:0]   mode,
  output logic [N-1:0] count,
  output logic         tic,
  output logic         at_max,
  output logic         at_min,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state, state_nxt;
  logic [N-1:0] count_nxt;
  logic [N-1:0] count_inc;
  logic         tic_nxt;
  logic         wrap_m;
  logic         oneshot_m;
  logic         can_step;

  assign at_max    = (count >= limit);
  assign at_min    = (count == '0);
  assign busy      = (state == RUN);
  assign count_inc = count + ONE;

  // Mode 11 is reserved and behaves as wrap.
  assign wrap_m    = (mode == 2'b00) || (mode == 2'b11);
  assign oneshot_m = (mode == 2'b10);

  // A one-shot counter sitting in IDLE can only be armed by load.
  assign can_step  = en && ((state == RUN) || ((state == IDLE) && !oneshot_m));

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tic_nxt   = 1'b0;
    if (clr) begin
      count_nxt = '0;
      state_nxt = IDLE;
    end else if (load) begin
      count_nxt = load_val;
      state_nxt = RUN;
    end else if (can_step) begin
      if (state == IDLE) state_nxt = RUN;
      if (wrap_m) begin
        if (up) begin
          if (at_max) begin
            count_nxt = '0;
            tic_nxt   = 1'b1;
          end else begin
            count_nxt = count_inc;
          end
        end else begin
          if (at_min) begin
            count_nxt = limit;
            tic_nxt   = 1'b1;
          end else begin
            count_nxt = count - ONE;
          end
        end
      end else begin
        // Saturate and one-shot: the tic fires only on the step that lands on the bound.
        if (up) begin
          if (at_max) begin
            count_nxt = limit;
          end else begin
            count_nxt = count_inc;
            tic_nxt   = (count_inc == limit);
          end
        end else if (!at_min) begin
          count_nxt = count - ONE;
          tic_nxt   = (count == ONE);
        end
        if (oneshot_m && tic_nxt) state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      tic   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tic   <= tic_nxt;
    end
  end

endmodule

// File: tb/tb_count_mod_n.sv
// Directed bench for count_mod_n (N=4): wrap, saturate, one-shot, priority, limit corner cases, reset.
module tb_count_mod_n;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] limit;
  logic [1:0]   mode;
  logic [N-1:0] count;
  logic         tic;
  logic         at_max;
  logic         at_min;
  logic         busy;

  int checks = 0;
  int errors = 0;

  count_mod_n #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
    .count    (count),
    .tic      (tic),
    .at_max   (at_max),
    .at_min   (at_min),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctb(input string tag, input int c, input int t, input int b);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tic"},   32'(tic),   32'(t));
    check({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    int sat_up_c[6]  = '{1, 2, 3, 3, 3, 3};
    int sat_up_t[6]  = '{0, 0, 1, 0, 0, 0};
    int sat_dn_c[4]  = '{2, 1, 0, 0};
    int sat_dn_t[4]  = '{0, 0, 1, 0};
    int os_c[3]      = '{2, 3, 4};
    int os_t[3]      = '{0, 0, 1};
    int os_b[3]      = '{1, 1, 0};
    int wd_c[3]      = '{5, 4, 3};
    int wd_t[3]      = '{1, 0, 0};

    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0; limit = 4'd9; mode = 2'b00;
    tick(); tick();
    chk_ctb("reset", 0, 0, 0);
    check("reset.at_min", 32'(at_min), 1);
    check("reset.at_max", 32'(at_max), 0);

    // Wrap, limit 9, counting up from reset.
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_ctb($sformatf("wrap_up%0d", i), i % 10, (i == 10) ? 1 : 0, 1);
      check($sformatf("wrap_up%0d.at_max", i), 32'(at_max), (i == 9) ? 1 : 0);
    end

    // Wrap down from a load of 0 with limit 5.
    en = 1'b0; limit = 4'd5; load_val = 4'd0; load = 1'b1;
    tick();
    chk_ctb("wrap_load", 0, 0, 1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctb($sformatf("wrap_dn%0d", i), wd_c[i], wd_t[i], 1);
    end

    // Saturate, limit 3.
    en = 1'b0; clr = 1'b1;
    tick();
    chk_ctb("clr", 0, 0, 0);
    clr = 1'b0; mode = 2'b01; limit = 4'd3; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_ctb($sformatf("sat_up%0d", i), sat_up_c[i], sat_up_t[i], 1);
    end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ctb($sformatf("sat_dn%0d", i), sat_dn_c[i], sat_dn_t[i], 1);
    end

    // One-shot, limit 4.
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; mode = 2'b10; limit = 4'd4; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctb($sformatf("os_idle%0d", i), 0, 0, 0);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    tick();
    chk_ctb("os_load", 1, 0, 1);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctb($sformatf("os_run%0d", i), os_c[i], os_t[i], os_b[i]);
    end
    tick(); tick();
    chk_ctb("os_done", 4, 0, 0);
    mode = 2'b00;
    tick();
    chk_ctb("os_done_modechg", 4, 0, 0);
    clr = 1'b1;
    tick();
    chk_ctb("os_clr", 0, 0, 0);
    clr = 1'b0; mode = 2'b10;
    tick();
    chk_ctb("os_idle_after_clr", 0, 0, 0);

    // Priority: clr > load > step.
    mode = 2'b00; limit = 4'd9; en = 1'b0; load_val = 4'd6; load = 1'b1;
    tick();
    chk_ctb("pri_load6", 6, 0, 1);
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd3;
    tick();
    chk_ctb("pri_clr", 0, 0, 0);
    clr = 1'b0;
    tick();
    chk_ctb("pri_load_over_step", 3, 0, 1);

    // limit = 0: wrap tics on every step, saturate neither moves nor tics.
    load = 1'b0; limit = 4'd0;
    tick();
    chk_ctb("lim0_wrap_a", 0, 1, 1);
    tick();
    chk_ctb("lim0_wrap_b", 0, 1, 1);
    check("lim0.at_max", 32'(at_max), 1);
    up = 1'b0;
    tick();
    chk_ctb("lim0_wrap_dn", 0, 1, 1);
    mode = 2'b01; up = 1'b1;
    tick();
    chk_ctb("lim0_sat", 0, 0, 1);

    // Limit lowered below count: up step counts as at bound.
    mode = 2'b00; en = 1'b0; limit = 4'd9; load_val = 4'd8; load = 1'b1;
    tick();
    load = 1'b0; limit = 4'd5;
    #1;
    check("lowered.at_max", 32'(at_max), 1);
    en = 1'b1; up = 1'b1;
    tick();
    chk_ctb("lowered_wrap", 0, 1, 1);
    mode = 2'b01; en = 1'b0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk_ctb("lowered_sat_up", 5, 0, 1);
    en = 1'b0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    chk_ctb("lowered_sat_dn", 7, 0, 1);

    // Reset mid-count, and reset overriding a tic due that edge.
    mode = 2'b00; limit = 4'd9; en = 1'b0; load_val = 4'd0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (7) tick();
    chk_ctb("pre_rst", 7, 0, 1);
    rst = 1'b0;
    tick();
    chk_ctb("rst_mid", 0, 0, 0);
    tick();
    chk_ctb("rst_hold", 0, 0, 0);
    rst = 1'b1; en = 1'b0; load_val = 4'd9; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; rst = 1'b0;
    tick();
    chk_ctb("rst_over_tic", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
